// File: rtl/mole_round_if.sv
// Handshake bundle between the whack-a-mole round controller, the centisecond
// counter stage and the button/LED front end.
interface mole_round_if #(parameter int N_HOLES = 8);
  logic               start;
  logic [N_HOLES-1:0] buttons;
  logic [9:0]         timer_cs;
  logic               timer_clr;
  logic [N_HOLES-1:0] mole;
  logic [7:0]         score;
  logic [7:0]         misses;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               busy;
  logic               done;

  modport master (
    output start, buttons, timer_cs,
    input  timer_clr, mole, score, misses, hit_pulse, miss_pulse, busy, done
  );

  modport slave (
    input  start, buttons, timer_cs,
    output timer_clr, mole, score, misses, hit_pulse, miss_pulse, busy, done
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: picks holes from an LFSR, times the gap/up
// windows against the external centisecond counter and tallies hits and misses.
module mole_round_ctrl #(
  parameter int         N_HOLES     = 8,
  parameter int         UP_TIME_CS  = 100,
  parameter int         GAP_CS      = 50,
  parameter int         ROUND_MOLES = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic        clk,
  input logic        reset,
  mole_round_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_e;

  state_e             state_q, state_d;
  logic               arm_q, arm_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] buttons_q;
  logic [2:0]         prev_hole_q, prev_hole_d;
  logic [7:0]         moles_left_q, moles_left_d;
  logic [N_HOLES-1:0] mole_q, mole_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         misses_q, misses_d;
  logic               hit_q, hit_d, miss_q, miss_d, clr_q, clr_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               win_end;

  logic [N_HOLES-1:0] press;
  logic [2:0]         h_raw, h_inc, hole;

  assign press  = bus.buttons & ~buttons_q;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Never light the same hole twice in a row.
  assign h_raw = 3'(32'(lfsr_q[2:0]) % N_HOLES);
  assign h_inc = 3'((32'(h_raw) + 32'd1) % N_HOLES);
  assign hole  = (h_raw == prev_hole_q) ? h_inc : h_raw;

  always_comb begin
    state_d      = state_q;
    mole_d       = mole_q;
    score_d      = score_q;
    misses_d     = misses_q;
    moles_left_d = moles_left_q;
    prev_hole_d  = prev_hole_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    clr_d        = 1'b0;
    win_end      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          score_d      = '0;
          misses_d     = '0;
          moles_left_d = 8'(ROUND_MOLES);
          state_d      = GAP;
          clr_d        = 1'b1;
        end
      end
      GAP: begin
        if (arm_q && bus.timer_cs >= 10'(GAP_CS)) begin
          mole_d      = N_HOLES'(1) << hole;
          prev_hole_d = hole;
          state_d     = UP;
          clr_d       = 1'b1;
        end
      end
      UP: begin
        // A hit beats a timeout landing on the same cycle.
        if (arm_q) begin
          if ((press & mole_q) != '0) begin
            hit_d   = 1'b1;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            win_end = 1'b1;
          end else if (bus.timer_cs >= 10'(UP_TIME_CS)) begin
            miss_d   = 1'b1;
            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
            win_end  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (win_end) begin
      mole_d       = '0;
      moles_left_d = moles_left_q - 8'd1;
      if (moles_left_q == 8'd1) begin
        state_d = DONE;
      end else begin
        state_d = GAP;
        clr_d   = 1'b1;
      end
    end
    // The count is stale on the clear cycle; hold off comparisons until after it.
    arm_d  = !clr_d;
    busy_d = (state_d == GAP) || (state_d == UP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      arm_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      buttons_q    <= '0;
      prev_hole_q  <= '0;
      moles_left_q <= '0;
      mole_q       <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      lfsr_q       <= lfsr_d;
      buttons_q    <= bus.buttons;
      prev_hole_q  <= prev_hole_d;
      moles_left_q <= moles_left_d;
      mole_q       <= mole_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      clr_q        <= clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.timer_clr  = clr_q;
  assign bus.mole       = mole_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: models the centisecond counter and the hole LFSR,
// drives per-mole plans from a table and scores hit/miss pulses from a queue.
module tb_mole_round_ctrl;
  localparam int         NH    = 8;
  localparam int         UPT   = 100;
  localparam int         GAPT  = 50;
  localparam int         RM    = 3;
  localparam logic [7:0] SEED  = 8'hA5;
  localparam int         NVEC  = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mole_round_if #(.N_HOLES(NH)) bus();

  mole_round_ctrl #(
    .N_HOLES(NH), .UP_TIME_CS(UPT), .GAP_CS(GAPT), .ROUND_MOLES(RM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Counter stage: +1 every 4 clocks, cleared the cycle after timer_clr.
  int div = 0;
  always @(posedge clk) begin
    if (reset || bus.timer_clr) begin
      bus.timer_cs <= '0;
      div          <= 0;
    end else if (div == 3) begin
      div          <= 0;
      bus.timer_cs <= bus.timer_cs + 10'd1;
    end else begin
      div <= div + 1;
    end
  end

  // Reference LFSR; m_prev is the value the DUT used at the last edge.
  logic [7:0] m_lfsr = SEED;
  logic [7:0] m_prev = SEED;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= reset ? SEED : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic bail(input string nm);
    n_chk++;
    $display("FAIL %s: wait expired", nm);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  typedef struct {
    bit         hit;
    logic [7:0] score;
    logic [7:0] misses;
  } res_t;
  res_t sb[$];

  logic [NH-1:0] mole_last = '0;
  int            tb_prev = 0;
  always @(posedge clk) begin
    int   h;
    res_t e;
    #1;
    if (reset) begin
      tb_prev = 0;
    end else begin
      if (mole_last == '0 && bus.mole != '0) begin
        h = int'(m_prev[2:0]) % NH;
        if (h == tb_prev) h = (h + 1) % NH;
        chk("mole_hole", 32'(bus.mole), 32'(1) << h);
        tb_prev = h;
      end
      if (bus.hit_pulse || bus.miss_pulse) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus.hit_pulse, bus.miss_pulse}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result_hit",  32'(bus.hit_pulse),  32'(e.hit));
          chk("result_miss", 32'(bus.miss_pulse), 32'(!e.hit));
          chk("score",       32'(bus.score),      32'(e.score));
          chk("misses",      32'(bus.misses),     32'(e.misses));
          chk("mole_clear",  32'(bus.mole),       32'd0);
        end
      end
    end
    mole_last = bus.mole;
  end

  typedef struct {
    int press_cs;    // -1: never press
    bit hold;        // all buttons held from GAP, release and re-press at press_cs
    bit wrong;       // press only the other holes at press_cs
    bit poke_start;  // pulse start mid-UP (must be ignored)
    bit exp_hit;
  } vec_t;
  vec_t vt[NVEC];

  int exp_score = 0;
  int exp_miss  = 0;

  task automatic wait_cs(input int c);
    int cnt = 0;
    while (int'(bus.timer_cs) != c) begin
      @(negedge clk);
      cnt++;
      if (cnt > 2000) bail("timer_wait");
    end
  endtask

  task automatic start_round();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("start_clr",    32'(bus.timer_clr), 32'd1);
    chk("start_busy",   32'(bus.busy),      32'd1);
    chk("start_done",   32'(bus.done),      32'd0);
    chk("start_score",  32'(bus.score),     32'd0);
    chk("start_misses", 32'(bus.misses),    32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    exp_score = 0;
    exp_miss  = 0;
    @(posedge clk); #1;
    chk("clr_one_cycle", 32'(bus.timer_clr), 32'd0);
  endtask

  task automatic run_mole(input vec_t v, input bit last);
    logic [NH-1:0] m;
    int cnt = 0;
    if (v.hold) bus.buttons = '1;
    while (bus.mole == '0) begin
      @(negedge clk);
      cnt++;
      if (cnt > 2000) bail("mole_wait");
    end
    m = bus.mole;
    @(negedge clk);
    chk("window_clear", 32'(bus.timer_cs), 32'd0);
    if (v.poke_start) begin
      wait_cs(20);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (!v.exp_hit) begin
      exp_miss++;
      sb.push_back('{1'b0, 8'(exp_score), 8'(exp_miss)});
    end
    if (v.press_cs >= 0) begin
      wait_cs(v.press_cs);
      if (v.hold) begin
        bus.buttons = '0;
        @(negedge clk);
      end
      if (v.wrong) begin
        bus.buttons = ~m;
      end else begin
        exp_score++;
        sb.push_back('{1'b1, 8'(exp_score), 8'(exp_miss)});
        bus.buttons = m;
      end
    end
    if (v.exp_hit) begin
      @(posedge clk); #1;
      chk("hit_latency", 32'(bus.hit_pulse), 32'd1);
    end else begin
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
      end while (!bus.miss_pulse && cnt < 600);
      if (!bus.miss_pulse) bail("miss_wait");
      chk("miss_at_cs", 32'(bus.timer_cs), 32'(UPT));
    end
    if (last) chk("round_end", {30'd0, bus.busy, bus.done}, 32'b01);
    else      chk("gap_resume", {30'd0, bus.busy, bus.timer_clr}, 32'b11);
    @(negedge clk);
    bus.buttons = '0;
  endtask

  initial begin
    int bad;
    vt[0] = '{30,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{-1,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{40,  1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{20,  1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{100, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{0,   1'b0, 1'b0, 1'b0, 1'b1};
    vt[6] = '{50,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{99,  1'b0, 1'b0, 1'b0, 1'b1};
    vt[8] = '{1,   1'b0, 1'b0, 1'b0, 1'b1};

    bus.start   = 1'b0;
    bus.buttons = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mole",   32'(bus.mole),       32'd0);
    chk("rst_score",  32'(bus.score),      32'd0);
    chk("rst_misses", 32'(bus.misses),     32'd0);
    chk("rst_flags",  {26'd0, bus.hit_pulse, bus.miss_pulse, bus.busy, bus.done,
                       bus.timer_clr, 1'b0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      if (i % RM == 0) start_round();
      run_mole(vt[i], (i % RM) == RM - 1);
      if (i % RM == RM - 1) begin
        chk("rnd_done",   32'(bus.done),   32'd1);
        chk("rnd_busy",   32'(bus.busy),   32'd0);
        chk("rnd_score",  32'(bus.score),  32'(exp_score));
        chk("rnd_misses", 32'(bus.misses), 32'(exp_miss));
      end
    end

    // Abandon a round mid-UP with a non-zero score.
    start_round();
    run_mole(vt[0], 1'b0);
    begin
      int cnt = 0;
      while (bus.mole == '0) begin
        @(negedge clk);
        cnt++;
        if (cnt > 2000) bail("mole_wait_rst");
      end
    end
    wait_cs(10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mole",  32'(bus.mole),   32'd0);
    chk("mid_rst_score", 32'(bus.score),  32'd0);
    chk("mid_rst_flags", {27'd0, bus.hit_pulse, bus.miss_pulse, bus.busy, bus.done,
                          bus.timer_clr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.busy || bus.timer_clr || bus.mole != '0) bad++;
    end
    chk("idle_after_rst", 32'(bad), 32'd0);

    // Hole choice must restart from the seed after reset.
    start_round();
    run_mole(vt[5], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
